// File: rtl/joybus_rx.sv
// JoyBus reply receiver: pulse-width bit decoder, MSB-first byte assembly and end-of-frame detection.
// Optional JB_RX_GLITCH_FILTER_EN adds a 3-sample agreement filter after the input synchronizer.
module joybus_rx #(
    parameter int BIT_THRESH   = 48,
    parameter int LOW_MAX      = 96,
    parameter int IDLE_TIMEOUT = 120,
    parameter int RESP_TIMEOUT = 720
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       JB_RX,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_data_vld,
    output logic [5:0] rx_byte_cnt,
    output logic       rx_done,
    output logic       rx_err
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_LOW        = 3'd2;
    localparam logic [2:0] ST_HIGH       = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [9:0] cnt;
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic       sync1;
    logic       sync2;
    logic       s;
    logic       s_prev;
    logic       fall;
    logic       rise;
    logic       bit_done;
    logic       bit_val;
    logic       end_err;

    // The line idles high, so the synchronizer resets high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= JB_RX;
            sync2 <= sync1;
        end
    end

`ifdef JB_RX_GLITCH_FILTER_EN
    logic hist1;
    logic hist2;
    logic s_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist1  <= 1'b1;
            hist2  <= 1'b1;
            s_hold <= 1'b1;
        end else begin
            hist1  <= sync2;
            hist2  <= hist1;
            s_hold <= s;
        end
    end

    // Follow the line only once three successive samples agree.
    always_comb begin
        s = s_hold;
        if (sync2 == hist1 && hist1 == hist2)
            s = sync2;
    end
`else
    assign s = sync2;
`endif

    assign fall    = s_prev & ~s;
    assign rise    = ~s_prev & s;
    assign rx_done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        bit_done  = 1'b0;
        bit_val   = 1'b0;
        end_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_en)
                    state_nxt = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!rx_en) begin
                    state_nxt = ST_IDLE;
                end else if (fall) begin
                    state_nxt = ST_LOW;
                end else if (cnt >= 10'(RESP_TIMEOUT)) begin
                    state_nxt = ST_DONE;
                    end_err   = 1'b1;
                end
            end
            // A stuck line outranks a rising edge seen in the same cycle.
            ST_LOW: begin
                if (!rx_en) begin
                    state_nxt = ST_IDLE;
                end else if (cnt >= 10'(LOW_MAX)) begin
                    state_nxt = ST_DONE;
                    end_err   = 1'b1;
                end else if (rise) begin
                    state_nxt = ST_HIGH;
                    bit_done  = 1'b1;
                    bit_val   = (cnt < 10'(BIT_THRESH));
                end
            end
            // The stop bit leaves exactly one bit in the next byte slot.
            ST_HIGH: begin
                if (!rx_en) begin
                    state_nxt = ST_IDLE;
                end else if (fall) begin
                    state_nxt = ST_LOW;
                end else if (cnt >= 10'(IDLE_TIMEOUT)) begin
                    state_nxt = ST_DONE;
                    end_err   = !(bit_cnt == 3'd1 && rx_byte_cnt != 6'd0);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            s_prev <= 1'b1;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            s_prev <= s;
            if (state_nxt != state || rise || fall)
                cnt <= '0;
            else if (cnt != 10'h3FF)
                cnt <= cnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift       <= '0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            rx_data_vld <= 1'b0;
            rx_byte_cnt <= '0;
            rx_err      <= 1'b0;
        end else begin
            rx_data_vld <= 1'b0;
            if (state == ST_IDLE && rx_en) begin
                bit_cnt     <= '0;
                rx_byte_cnt <= '0;
                rx_err      <= 1'b0;
            end
            if (bit_done) begin
                shift <= {shift[5:0], bit_val};
                if (bit_cnt == 3'd7) begin
                    rx_data     <= {shift, bit_val};
                    rx_data_vld <= 1'b1;
                    bit_cnt     <= '0;
                    if (rx_byte_cnt != 6'd63)
                        rx_byte_cnt <= rx_byte_cnt + 6'd1;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
            if (state_nxt == ST_DONE && state != ST_DONE)
                rx_err <= end_err;
        end
    end

endmodule
